// File: rtl/and4_pattern_tester.sv
// Purpose: walks a 4-bit pattern 0..F into an AND tile, checks its 1-bit response, counts mismatches.
// Latency: start edge to first pattern is 3 edges; each pattern is held SETTLE_CYCLES+1 cycles.
// Backpressure: none; the sequence is free-running and never waits on the tile.
module and4_pattern_tester #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] SETTLE  = SETTLE_CYCLES[3:0];
  localparam logic [4:0] ERR_MAX = 5'd16;

  // Pin breakout
  logic clk;
  logic rst;
  logic resp_raw;
  logic start_raw;
  logic pol_in;
  logic view_in;
  logic abort_raw;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign resp_raw  = io_in[2];
  assign start_raw = io_in[3];
  assign pol_in    = io_in[4];
  assign view_in   = io_in[5];
  assign unused_in = io_in[6];
  assign abort_raw = io_in[7];

  // Synchronizers and registered view select
  logic [1:0] start_sync;
  logic [1:0] abort_sync;
  logic [1:0] resp_sync;
  logic       start_dly;
  logic       view_q;

  // Core state
  logic [1:0] state;
  logic [3:0] pattern;
  logic [3:0] hold;
  logic [4:0] err_cnt;
  logic       pol;

  // Derived controls
  logic start_edge;
  logic abort_s;
  logic resp_s;
  logic compare;
  logic exp_bit;
  logic mismatch;
  logic busy;
  logic done;
  logic pass;
  logic fail;
  logic [3:0] cnt_view;
  logic [3:0] status_view;

  // Two-flop synchronizers for async pins; start_dly feeds the rising-edge detect.
  // The view select is registered so no pin reaches io_out combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= 2'b00;
      abort_sync <= 2'b00;
      resp_sync  <= 2'b00;
      start_dly  <= 1'b0;
      view_q     <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], start_raw};
      abort_sync <= {abort_sync[0], abort_raw};
      resp_sync  <= {resp_sync[0], resp_raw};
      start_dly  <= start_sync[1];
      view_q     <= view_in;
    end
  end

  assign start_edge = start_sync[1] & ~start_dly;
  assign abort_s    = abort_sync[1];
  assign resp_s     = resp_sync[1];

  // A response is judged on the last cycle of each pattern's hold window.
  assign compare  = (state == ST_DRIVE) && (hold == SETTLE);
  assign exp_bit  = (pattern == 4'hF) ^ pol;
  assign mismatch = compare && (resp_s != exp_bit);

  // Sequencer: IDLE/DONE park the pattern at 0, DRIVE steps it once per hold window.
  // Abort wins over everything, including a start edge in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pattern <= 4'h0;
      hold    <= 4'h0;
    end else if (abort_s) begin
      state   <= ST_IDLE;
      pattern <= 4'h0;
      hold    <= 4'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          pattern <= 4'h0;
          hold    <= 4'h0;
          if (start_edge) begin
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (compare) begin
            hold <= 4'h0;
            if (pattern == 4'hF) begin
              state <= ST_DONE;
            end else begin
              pattern <= pattern + 4'h1;
            end
          end else begin
            hold <= hold + 4'h1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pattern <= 4'h0;
          hold    <= 4'h0;
        end
      endcase
    end
  end

  // Error counter saturates at 16; polarity is captured only when a run is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 5'd0;
      pol     <= 1'b0;
    end else if (abort_s) begin
      err_cnt <= 5'd0;
    end else if (start_edge && (state != ST_DRIVE)) begin
      err_cnt <= 5'd0;
      pol     <= pol_in;
    end else if (mismatch && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + 5'd1;
    end
  end

  // Status decode is purely from registered state.
  assign busy = (state == ST_DRIVE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == 5'd0);
  assign fail = done && (err_cnt != 5'd0);

  assign cnt_view    = (err_cnt > 5'd15) ? 4'hF : err_cnt[3:0];
  assign status_view = {fail, pass, done, busy};

  assign io_out = {(view_q ? cnt_view : status_view), pattern};

endmodule

// File: tb/tb_and4_pattern_tester.sv
// Bench for and4_pattern_tester: a behavioural tile model answers the driven pattern,
// full runs come from a vector table, and abort/reset/start corner cases are hand sequences.
module tb_and4_pattern_tester;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pol;
  logic       view;
  logic       abort;
  logic [1:0] mode;    // 0: AND, 1: NAND, 2: stuck-at-0, 3: stuck-at-1
  logic       resp;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_tests;
  int n_failed;

  and4_pattern_tester #(.SETTLE_CYCLES(3)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  assign resp = (mode == 2'd0) ? (&io_out[3:0]) :
                (mode == 2'd1) ? ~(&io_out[3:0]) :
                (mode == 2'd2) ? 1'b0 : 1'b1;

  assign io_in = {abort, 1'b0, view, pol, start, resp, rst, clk};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       pol;
    logic       exp_pass;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_busy(output bit ok);
    int g;
    g = 0;
    while (!io_out[4] && g < 10) begin
      tick();
      g++;
    end
    ok = io_out[4];
  endtask

  // Launches a run and follows it to the end. The polarity pin is flipped
  // mid-run to confirm it only matters at launch.
  task automatic do_run(input bit pol_i, input bit keep_start, input int repulse_at,
                        output int n_busy, output int pat_bad, output bit timed_out,
                        output logic [3:0] status);
    bit ok;
    pol   = pol_i;
    start = 1'b1;
    tick();
    tick();
    if (!keep_start) start = 1'b0;
    wait_busy(ok);
    timed_out = !ok;
    n_busy    = 0;
    pat_bad   = 0;
    while (io_out[4] && n_busy < 200) begin
      if (io_out[3:0] != 4'(n_busy / 4)) pat_bad++;
      if (io_out[7:4] != 4'b0001) pat_bad++;
      n_busy++;
      if (n_busy == 8) pol = ~pol_i;
      if (n_busy == repulse_at) start = 1'b1;
      if (n_busy == repulse_at + 2) start = 1'b0;
      tick();
    end
    if (n_busy >= 200) timed_out = 1'b1;
    status = io_out[7:4];
  endtask

  int         nb;
  int         pb;
  bit         to;
  bit         ok;
  logic [3:0] st;
  int         g;

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    pol   = 1'b0;
    view  = 1'b0;
    abort = 1'b0;
    mode  = 2'd0;

    vecs[0] = '{mode: 2'd0, pol: 1'b0, exp_pass: 1'b1, exp_cnt: 4'h0};
    vecs[1] = '{mode: 2'd2, pol: 1'b0, exp_pass: 1'b0, exp_cnt: 4'h1};
    vecs[2] = '{mode: 2'd2, pol: 1'b1, exp_pass: 1'b0, exp_cnt: 4'hF};
    vecs[3] = '{mode: 2'd1, pol: 1'b1, exp_pass: 1'b1, exp_cnt: 4'h0};
    vecs[4] = '{mode: 2'd3, pol: 1'b1, exp_pass: 1'b0, exp_cnt: 4'h1};
    vecs[5] = '{mode: 2'd3, pol: 1'b0, exp_pass: 1'b0, exp_cnt: 4'hF};
    vecs[6] = '{mode: 2'd1, pol: 1'b0, exp_pass: 1'b0, exp_cnt: 4'hF};
    vecs[7] = '{mode: 2'd0, pol: 1'b1, exp_pass: 1'b0, exp_cnt: 4'hF};

    // Reset state
    #1;
    check("reset_io_out", io_out, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("idle_after_reset", io_out, 8'h00);

    // Start latency: DRIVE with pattern 0 appears after the third edge
    mode  = 2'd0;
    pol   = 1'b0;
    start = 1'b1;
    tick();
    tick();
    check("start_lat_early", io_out[4], 0);
    tick();
    check("start_lat_drive", io_out, 8'h10);
    start = 1'b0;
    g = 0;
    while (io_out[4] && g < 100) begin
      tick();
      g++;
    end
    check("start_lat_done", io_out[7:4], 4'b0110);

    // Full runs from the vector table
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      do_run(vecs[i].pol, 1'b0, -1, nb, pb, to, st);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_run_len", i), nb, 64);
      check($sformatf("v%0d_pattern_walk", i), pb, 0);
      check($sformatf("v%0d_status", i), st,
            {~vecs[i].exp_pass, vecs[i].exp_pass, 2'b10});
      view = 1'b1;
      tick();
      check($sformatf("v%0d_pattern_zero", i), io_out[3:0], 4'h0);
      check($sformatf("v%0d_err_count", i), io_out[7:4], vecs[i].exp_cnt);
      view = 1'b0;
      tick();
    end

    // Abort at busy cycle 20
    mode  = 2'd0;
    pol   = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_busy(ok);
    check("abort_run_started", ok, 1);
    repeat (20) tick();
    abort = 1'b1;
    tick();
    tick();
    check("abort_sync_latency", io_out[4], 1);
    tick();
    check("abort_clear", io_out, 8'h00);
    abort = 1'b0;
    repeat (8) tick();
    check("abort_no_done", io_out, 8'h00);
    do_run(1'b0, 1'b0, -1, nb, pb, to, st);
    check("after_abort_len", nb, 64);
    check("after_abort_status", st, 4'b0110);

    // Start re-pulsed mid-run is ignored
    do_run(1'b0, 1'b0, 10, nb, pb, to, st);
    check("repulse_len", nb, 64);
    check("repulse_walk", pb, 0);
    check("repulse_status", st, 4'b0110);
    tick();

    // Reset at busy cycle 30 clears outputs without a clock
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_busy(ok);
    check("reset_run_started", ok, 1);
    repeat (30) tick();
    rst = 1'b1;
    #1;
    check("reset_async_clear", io_out, 8'h00);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("reset_stays_idle", io_out, 8'h00);

    // Start held high gives exactly one run
    do_run(1'b0, 1'b1, -1, nb, pb, to, st);
    check("held_len", nb, 64);
    repeat (10) tick();
    check("held_one_run", io_out[7:4], 4'b0110);
    start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  // Hard stop if the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary, expected finish");
    $fatal(1, "timeout");
  end

endmodule
